// File: rtl/reaction_trial_sequencer_if.sv
// Bus between the trial sequencer and its external 8x16 register file.
// Writes land on the rising clock edge; reads are asynchronous.
interface reaction_trial_sequencer_if;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;

    modport master (output wr_en, output wr_addr, output wr_data, output rd_addr, input rd_data);
    modport slave  (input wr_en, input wr_addr, input wr_data, input rd_addr, output rd_data);
endinterface

// File: rtl/reaction_trial_sequencer.sv
// Stores up to eight reaction trials in a ring of register-file slots and, on request,
// sums the valid slots and divides by the count to produce the floor average.
module reaction_trial_sequencer #(
    parameter int MAX_TIME = 9999
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trial_done,
    input  logic [15:0]                   trial_time,
    input  logic                          avg_req,
    input  logic                          clear,
    reaction_trial_sequencer_if.master    rf,
    output logic [3:0]                    count,
    output logic                          full,
    output logic [7:0]                    slot_onehot,
    output logic                          busy,
    output logic                          overrun,
    output logic                          avg_valid,
    output logic [13:0]                   avg_out
);
    typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} state_t;

    localparam logic [15:0] MAX_CLAMP = 16'(MAX_TIME);

    state_t      state;
    state_t      state_next;
    logic [2:0]  wr_ptr;
    logic [4:0]  step;
    logic [16:0] acc;
    logic [3:0]  rem;
    logic        write_ok;
    logic [3:0]  count_after;
    logic [4:0]  count5;
    logic [4:0]  div_trial;
    logic        div_ge;
    logic [3:0]  div_rem;

    // The count as it will be after a coincident write, so a same-cycle request sees the new trial.
    always_comb begin
        write_ok    = trial_done && (state == IDLE) && !clear && !rst;
        count_after = count;
        if (write_ok && (count != 4'd8)) begin
            count_after = count + 4'd1;
        end
        count5    = {1'b0, count};
        div_trial = {rem, acc[16]};
        div_ge    = (div_trial >= count5);
        div_rem   = div_ge ? 4'(div_trial - count5) : div_trial[3:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (avg_req) state_next = (count_after != 4'd0) ? SUM : DONE;
            SUM:  if (step == count5 - 5'd1) state_next = DIV;
            DIV:  if (step == 5'd16) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // acc holds the running sum in SUM, then shifts into the quotient during DIV.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= 3'd0;
            count   <= 4'd0;
            overrun <= 1'b0;
            avg_out <= 14'd0;
            step    <= 5'd0;
            acc     <= 17'd0;
            rem     <= 4'd0;
        end else if (clear) begin
            wr_ptr  <= 3'd0;
            count   <= 4'd0;
            overrun <= 1'b0;
            avg_out <= 14'd0;
        end else begin
            if (write_ok) begin
                wr_ptr <= wr_ptr + 3'd1;
                count  <= count_after;
            end
            if (trial_done && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    step <= 5'd0;
                    acc  <= 17'd0;
                    rem  <= 4'd0;
                    if (avg_req && (count_after == 4'd0)) begin
                        avg_out <= 14'd0;
                    end
                end
                SUM: begin
                    acc  <= acc + {1'b0, rf.rd_data};
                    rem  <= 4'd0;
                    step <= (step == count5 - 5'd1) ? 5'd0 : step + 5'd1;
                end
                DIV: begin
                    acc  <= {acc[15:0], div_ge};
                    rem  <= div_rem;
                    step <= step + 5'd1;
                    if (step == 5'd16) begin
                        avg_out <= {acc[12:0], div_ge};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rf.wr_en   = write_ok;
    assign rf.wr_addr = wr_ptr;
    assign rf.wr_data = (trial_time > MAX_CLAMP) ? MAX_CLAMP : trial_time;
    assign rf.rd_addr = (state == SUM) ? step[2:0] : 3'd0;

    assign full        = (count == 4'd8);
    assign slot_onehot = 8'd1 << wr_ptr;
    assign busy        = (state == SUM) || (state == DIV);
    assign avg_valid   = (state == DONE);
endmodule

// File: tb/tb_reaction_trial_sequencer.sv
// Randomised and directed bench for reaction_trial_sequencer against a transaction-level
// model: slots as an array, the average computed by plain division, latency as a countdown.
module tb_reaction_trial_sequencer;
    localparam int MAX_TIME = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trial_done = 1'b0;
    logic [15:0] trial_time = 16'd0;
    logic        avg_req = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  count;
    logic        full;
    logic [7:0]  slot_onehot;
    logic        busy;
    logic        overrun;
    logic        avg_valid;
    logic [13:0] avg_out;

    reaction_trial_sequencer_if rf_bus();
    logic [15:0] rf_mem [8];

    always #5 clk = ~clk;

    assign rf_bus.rd_data = rf_mem[rf_bus.rd_addr];
    always @(posedge clk) if (rf_bus.wr_en) rf_mem[rf_bus.wr_addr] <= rf_bus.wr_data;

    reaction_trial_sequencer #(.MAX_TIME(MAX_TIME)) dut (
        .clk(clk), .rst(rst), .trial_done(trial_done), .trial_time(trial_time),
        .avg_req(avg_req), .clear(clear), .rf(rf_bus), .count(count), .full(full),
        .slot_onehot(slot_onehot), .busy(busy), .overrun(overrun),
        .avg_valid(avg_valid), .avg_out(avg_out)
    );

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== 32'(expected)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: m_left counts cycles remaining until the result cycle.
    bit m_ready = 0;
    bit m_active = 0;
    int m_left, m_n, m_cnt, m_ptr, m_avg, m_pending, m_over;
    int m_slots [8];

    function automatic int clampTime(input int t);
        return (t > MAX_TIME) ? MAX_TIME : t;
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) rf_mem[i] = 16'd0;
        forever begin
            @(posedge clk);
            if (rst || clear) begin
                if (rst) m_ready = 1;
                m_active = 0; m_left = 0; m_cnt = 0; m_ptr = 0; m_avg = 0; m_over = 0;
            end else begin
                automatic bit was_active = m_active;
                if (trial_done) begin
                    if (!was_active) begin
                        m_slots[m_ptr] = clampTime(int'(trial_time));
                        m_ptr = (m_ptr + 1) % 8;
                        if (m_cnt < 8) m_cnt++;
                    end else begin
                        m_over = 1;
                    end
                end
                if (was_active) begin
                    if (m_left == 0) m_active = 0;
                    else begin
                        m_left--;
                        if (m_left == 0) m_avg = m_pending;
                    end
                end else if (avg_req) begin
                    m_active = 1;
                    if (m_cnt > 0) begin
                        automatic int sum = 0;
                        for (int i = 0; i < m_cnt; i++) sum += m_slots[i];
                        m_pending = sum / m_cnt;
                        m_n = m_cnt;
                        m_left = m_cnt + 17;
                    end else begin
                        m_left = 0;
                        m_avg = 0;
                    end
                end
            end
        end
    end

    // Every cycle, compare all outputs against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ready) begin
                automatic bit exp_wr = trial_done && !m_active && !clear && !rst;
                automatic int elapsed = m_n + 17 - m_left;
                automatic int exp_rd = (m_active && m_left > 0 && elapsed < m_n) ? elapsed : 0;
                checkOutput("wr_en", 32'(rf_bus.wr_en), int'(exp_wr));
                if (exp_wr) begin
                    checkOutput("wr_addr", 32'(rf_bus.wr_addr), m_ptr);
                    checkOutput("wr_data", 32'(rf_bus.wr_data), clampTime(int'(trial_time)));
                end
                checkOutput("count", 32'(count), m_cnt);
                checkOutput("full", 32'(full), int'(m_cnt == 8));
                checkOutput("slot_onehot", 32'(slot_onehot), 1 << m_ptr);
                checkOutput("busy", 32'(busy), int'(m_active && m_left > 0));
                checkOutput("avg_valid", 32'(avg_valid), int'(m_active && m_left == 0));
                checkOutput("overrun", 32'(overrun), m_over);
                checkOutput("avg_out", 32'(avg_out), m_avg);
                checkOutput("rd_addr", 32'(rf_bus.rd_addr), exp_rd);
            end
        end
    end

    task automatic applyStimulus(input logic td, input logic [15:0] tt, input logic ar,
                                 input logic cl, input logic rs);
        trial_done = td; trial_time = tt; avg_req = ar; clear = cl; rst = rs;
        @(posedge clk);
        #1;
        trial_done = 1'b0; trial_time = 16'd0; avg_req = 1'b0; clear = 1'b0; rst = 1'b0;
    endtask

    // Called in the cycle after avg_req; k is the cycle offset from avg_req, -1 on timeout.
    task automatic waitValid(output int k, output bit busy_seen);
        k = -1;
        busy_seen = 0;
        for (int i = 1; i <= 200; i++) begin
            if (busy) busy_seen = 1;
            if (avg_valid) begin
                k = i;
                break;
            end
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int k;
        bit busy_seen;
        bit seen;

        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_onehot", 32'(slot_onehot), 1);
        checkOutput("rst_avg_out", 32'(avg_out), 0);
        checkOutput("rst_busy", 32'(busy), 0);

        applyStimulus(1'b1, 16'd100, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd301, 1'b0, 1'b0, 1'b0);
        checkOutput("three_count", 32'(count), 3);
        checkOutput("three_onehot", 32'(slot_onehot), 8);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        waitValid(k, busy_seen);
        checkOutput("three_latency", 32'(k), 21);
        checkOutput("three_avg", 32'(avg_out), 200);

        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 16'(1000 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("nine_count", 32'(count), 8);
        checkOutput("nine_full", 32'(full), 1);
        checkOutput("nine_onehot", 32'(slot_onehot), 2);
        checkOutput("nine_slot0", 32'(rf_mem[0]), 1008);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        waitValid(k, busy_seen);
        checkOutput("nine_latency", 32'(k), 26);
        checkOutput("nine_avg", 32'(avg_out), 1004);

        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        waitValid(k, busy_seen);
        checkOutput("empty_latency", 32'(k), 1);
        checkOutput("empty_avg", 32'(avg_out), 0);
        checkOutput("empty_busy_seen", 32'(busy_seen), 0);

        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        trial_done = 1'b1; trial_time = 16'd12000;
        #1;
        checkOutput("clamp_wr_en", 32'(rf_bus.wr_en), 1);
        checkOutput("clamp_wr_data", 32'(rf_bus.wr_data), 9999);
        @(posedge clk);
        #1;
        trial_done = 1'b0; trial_time = 16'd0;
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        trial_done = 1'b1; trial_time = 16'd500;
        #1;
        checkOutput("div_drop_wr_en", 32'(rf_bus.wr_en), 0);
        @(posedge clk);
        #1;
        trial_done = 1'b0; trial_time = 16'd0;
        checkOutput("div_overrun", 32'(overrun), 1);
        checkOutput("div_count", 32'(count), 1);
        waitValid(k, busy_seen);
        checkOutput("clamp_latency", 32'(k), 17);
        checkOutput("clamp_avg", 32'(avg_out), 9999);

        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd20, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_count", 32'(count), 0);
        checkOutput("abort_avg", 32'(avg_out), 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (avg_valid) seen = 1;
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("abort_no_valid", 32'(seen), 0);

        applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd6, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd9, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("sumrst_count", 32'(count), 0);
        checkOutput("sumrst_busy", 32'(busy), 0);
        checkOutput("sumrst_overrun", 32'(overrun), 0);
        checkOutput("sumrst_onehot", 32'(slot_onehot), 1);
        checkOutput("sumrst_rd_addr", 32'(rf_bus.rd_addr), 0);
        applyStimulus(1'b1, 16'd42, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        waitValid(k, busy_seen);
        checkOutput("sumrst_latency", 32'(k), 19);
        checkOutput("sumrst_avg", 32'(avg_out), 42);

        for (int i = 0; i < 4000; i++) begin
            automatic int r = int'($urandom_range(0, 999));
            applyStimulus(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                          16'($urandom_range(0, 16000)),
                          ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                          (r < 8) ? 1'b1 : 1'b0,
                          (r >= 995) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
